uart_tx_fifo_ctrl_p: RTL and testbench

Parametrised UART transmit buffer between the DSP register bus (DSP_CLK domain) and the UART Tx controller. It contains a one-entry holding register that feeds the Tx controller, backed by a FIFO of programmable depth. It adds four things: a software flush, a programmable trigger level, an entry-count output and a sticky overflow flag. TxDone from the Tx controller is asynchronous to DSP_CLK and is synchronised inside the block.

---
 rtl/uart_tx_fifo_ctrl_p.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo_ctrl_p.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl_p.sv
// UART transmit buffer: a holding register that feeds the Tx controller, backed by a
// programmable-depth FIFO, with flush, trigger level, entry count and sticky overflow.
module uart_tx_fifo_ctrl_p #(
  parameter int DATA_W      = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ADDR_W      = 4,
  parameter int TXDATA_ADDR = 0
) (
  input  logic                  RESETn,
  input  logic                  DSP_CLK,
  input  logic                  DSP_CEn,
  input  logic                  DSP_WEn,
  input  logic [ADDR_W-1:0]     DSP_ADDR,
  input  logic [31:0]           DSP_WDATA,
  input  logic                  FIFOEn,
  input  logic                  FifoFlush,
  input  logic                  OvfClr,
  input  logic [DEPTH_LOG2:0]   TrigLevel,
  input  logic                  TxDone,
  output logic                  TxDataReady,
  output logic [DATA_W-1:0]     TxData,
  output logic [DEPTH_LOG2:0]   TxFIFO_Level,
  output logic                  TxFIFO_Empty,
  output logic                  TxFIFO_Full,
  output logic                  TxFIFO_Trig,
  output logic                  Overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_VAL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0] wp, rp;
  logic s1, s2, s3;
  logic wr, done;
  logic push, pop, load_wdata, clr_ready, set_ovf;
  logic [DATA_W-1:0] wdata;
  logic unused_wdata_bits;

  assign wdata = DSP_WDATA[DATA_W-1:0];
  assign unused_wdata_bits = ^DSP_WDATA;

  assign wr   = !DSP_CEn && !DSP_WEn && (DSP_ADDR == ADDR_W'(TXDATA_ADDR));
  assign done = s2 && !s3;

  assign TxFIFO_Level = wp - rp;
  assign TxFIFO_Empty = (TxFIFO_Level == '0);
  assign TxFIFO_Full  = (TxFIFO_Level == DEPTH_VAL);
  // A TrigLevel above DEPTH can never be reached, so the compare alone covers both extremes.
  assign TxFIFO_Trig  = (TxFIFO_Level >= TrigLevel);

  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= TxDone;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Priority decode of flush, load, reload/pop, push and drop.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    load_wdata = 1'b0;
    clr_ready  = 1'b0;
    set_ovf    = 1'b0;
    if (FifoFlush) begin
      clr_ready = 1'b1;
    end else if (!TxDataReady) begin
      load_wdata = wr;
    end else if (done && TxFIFO_Empty) begin
      load_wdata = wr;
      clr_ready  = !wr;
    end else if (done) begin
      pop = 1'b1;
      if (wr) begin
        push    = FIFOEn;
        set_ovf = !FIFOEn;
      end
    end else if (wr) begin
      push    = FIFOEn && !TxFIFO_Full;
      set_ovf = !(FIFOEn && !TxFIFO_Full);
    end
  end

  always_ff @(posedge DSP_CLK) begin
    if (push) begin
      mem[wp[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      wp          <= '0;
      rp          <= '0;
      TxDataReady <= 1'b0;
      TxData      <= '0;
      Overflow    <= 1'b0;
    end else begin
      if (FifoFlush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
      end
      if (load_wdata) begin
        TxData      <= wdata;
        TxDataReady <= 1'b1;
      end else if (pop) begin
        TxData <= mem[rp[DEPTH_LOG2-1:0]];
      end else if (clr_ready) begin
        TxDataReady <= 1'b0;
      end
      if (set_ovf) begin
        Overflow <= 1'b1;
      end else if (OvfClr) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl_p.sv
// Directed self-checking bench for uart_tx_fifo_ctrl_p (DATA_W=8, DEPTH=16).
module tb_uart_tx_fifo_ctrl_p;

  logic        RESETn, DSP_CLK, DSP_CEn, DSP_WEn;
  logic [3:0]  DSP_ADDR;
  logic [31:0] DSP_WDATA;
  logic        FIFOEn, FifoFlush, OvfClr, TxDone;
  logic [4:0]  TrigLevel;
  logic        TxDataReady, TxFIFO_Empty, TxFIFO_Full, TxFIFO_Trig, Overflow;
  logic [7:0]  TxData;
  logic [4:0]  TxFIFO_Level;

  int passCount = 0;
  int checkCount = 0;

  uart_tx_fifo_ctrl_p #(.DATA_W(8), .DEPTH_LOG2(4), .ADDR_W(4), .TXDATA_ADDR(0)) dut (
    .RESETn(RESETn), .DSP_CLK(DSP_CLK), .DSP_CEn(DSP_CEn), .DSP_WEn(DSP_WEn),
    .DSP_ADDR(DSP_ADDR), .DSP_WDATA(DSP_WDATA), .FIFOEn(FIFOEn), .FifoFlush(FifoFlush),
    .OvfClr(OvfClr), .TrigLevel(TrigLevel), .TxDone(TxDone), .TxDataReady(TxDataReady),
    .TxData(TxData), .TxFIFO_Level(TxFIFO_Level), .TxFIFO_Empty(TxFIFO_Empty),
    .TxFIFO_Full(TxFIFO_Full), .TxFIFO_Trig(TxFIFO_Trig), .Overflow(Overflow)
  );

  initial DSP_CLK = 1'b0;
  always #5 DSP_CLK = ~DSP_CLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge DSP_CLK);
    #1;
  endtask

  // One bus write cycle at the transmit data address.
  task automatic applyStimulus(input logic [7:0] data);
    DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_WDATA = {24'h0, data};
    tick();
    DSP_CEn = 1'b1; DSP_WEn = 1'b1;
  endtask

  // TxDone pulse; the optional write lands in the same cycle as the pop.
  task automatic applyDone(input bit withWr, input logic [7:0] data);
    TxDone = 1'b1;
    tick();
    tick();
    if (withWr) begin
      DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_WDATA = {24'h0, data};
    end
    tick();
    DSP_CEn = 1'b1; DSP_WEn = 1'b1;
    TxDone = 1'b0;
    tick();
    tick();
  endtask

  task automatic flush();
    FifoFlush = 1'b1;
    tick();
    FifoFlush = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0; DSP_CEn = 1'b1; DSP_WEn = 1'b1; DSP_ADDR = 4'd0; DSP_WDATA = 32'h0;
    FIFOEn = 1'b1; FifoFlush = 1'b0; OvfClr = 1'b0; TrigLevel = 5'd0; TxDone = 1'b0;
    #13;
    checkOutput("rst_ready", TxDataReady, 0);
    checkOutput("rst_data", TxData, 8'h00);
    checkOutput("rst_level", TxFIFO_Level, 0);
    checkOutput("rst_empty", TxFIFO_Empty, 1);
    checkOutput("rst_full", TxFIFO_Full, 0);
    checkOutput("rst_trig0", TxFIFO_Trig, 1);
    checkOutput("rst_ovf", Overflow, 0);
    TrigLevel = 5'd5;
    #1;
    checkOutput("rst_trig5", TxFIFO_Trig, 0);
    RESETn = 1'b1;
    tick();

    // Write to a different address is not a transmit write.
    DSP_ADDR = 4'd1;
    applyStimulus(8'h99);
    DSP_ADDR = 4'd0;
    checkOutput("other_addr_ready", TxDataReady, 0);

    applyStimulus(8'h41);
    checkOutput("first_ready", TxDataReady, 1);
    checkOutput("first_data", TxData, 8'h41);
    checkOutput("first_level", TxFIFO_Level, 0);
    checkOutput("first_empty", TxFIFO_Empty, 1);
    flush();
    checkOutput("flush1_ready", TxDataReady, 0);

    // Fill: holding + 16 FIFO entries, 18th write dropped.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(8'h20 + 8'(i));
      if (i == 16) begin
        checkOutput("fill_full", TxFIFO_Full, 1);
        checkOutput("fill_level", TxFIFO_Level, 16);
        checkOutput("fill_ovf_before", Overflow, 0);
      end
    end
    checkOutput("fill_ovf", Overflow, 1);
    checkOutput("fill_level_after_drop", TxFIFO_Level, 16);
    checkOutput("fill_hold", TxData, 8'h20);
    TrigLevel = 5'd16;
    #1;
    checkOutput("trig16_full", TxFIFO_Trig, 1);
    TrigLevel = 5'd17;
    #1;
    checkOutput("trig17_full", TxFIFO_Trig, 0);
    OvfClr = 1'b1;
    tick();
    OvfClr = 1'b0;
    checkOutput("ovf_clr", Overflow, 0);

    // Full FIFO: pop and push in the same cycle.
    applyDone(1'b1, 8'hA5);
    checkOutput("fullrw_level", TxFIFO_Level, 16);
    checkOutput("fullrw_data", TxData, 8'h21);
    FIFOEn = 1'b0;
    applyStimulus(8'hB6);
    checkOutput("fifooff_ovf", Overflow, 1);
    checkOutput("fifooff_level", TxFIFO_Level, 16);
    applyDone(1'b0, 8'h00);
    checkOutput("fifooff_drain_data", TxData, 8'h22);
    checkOutput("fifooff_drain_level", TxFIFO_Level, 15);
    FIFOEn = 1'b1;
    for (int k = 0; k < 15; k++) begin
      applyDone(1'b0, 8'h00);
      checkOutput("drain_data", TxData, (k < 14) ? 8'h23 + 8'(k) : 8'hA5);
    end
    checkOutput("drain_level", TxFIFO_Level, 0);
    checkOutput("drain_ready", TxDataReady, 1);
    flush();
    OvfClr = 1'b1;
    tick();
    OvfClr = 1'b0;

    // Preload 5, then 6 done pulses.
    for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i));
    checkOutput("pre_level", TxFIFO_Level, 4);
    for (int k = 1; k <= 4; k++) begin
      applyDone(1'b0, 8'h00);
      checkOutput("pre_data", TxData, 8'h50 + 8'(k));
      checkOutput("pre_level_step", TxFIFO_Level, 5'(4 - k));
    end
    applyDone(1'b0, 8'h00);
    checkOutput("pre5_ready", TxDataReady, 0);
    applyDone(1'b0, 8'h00);
    checkOutput("pre6_ready", TxDataReady, 0);
    checkOutput("pre6_empty", TxFIFO_Empty, 1);
    checkOutput("pre6_data", TxData, 8'h54);

    // Interleaved write/pop across the pointer wrap.
    flush();
    applyStimulus(8'h80);
    applyStimulus(8'h81);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'h82 + 8'(i));
      checkOutput("wrap_level2", TxFIFO_Level, 2);
      applyDone(1'b0, 8'h00);
      checkOutput("wrap_data", TxData, 8'h81 + 8'(i));
      checkOutput("wrap_level1", TxFIFO_Level, 1);
    end

    // Flush with 7 entries and a write in the same cycle.
    flush();
    for (int i = 0; i < 8; i++) applyStimulus(8'h60 + 8'(i));
    checkOutput("fl_level7", TxFIFO_Level, 7);
    FifoFlush = 1'b1; DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_WDATA = 32'hEE;
    tick();
    FifoFlush = 1'b0; DSP_CEn = 1'b1; DSP_WEn = 1'b1;
    checkOutput("fl_level0", TxFIFO_Level, 0);
    checkOutput("fl_ready", TxDataReady, 0);
    checkOutput("fl_data_kept", TxData, 8'h60);
    applyStimulus(8'h11);
    checkOutput("fl_next_data", TxData, 8'h11);
    checkOutput("fl_next_level", TxFIFO_Level, 0);

    TrigLevel = 5'd4;
    for (int i = 0; i < 3; i++) applyStimulus(8'h12 + 8'(i));
    checkOutput("trig4_at3", TxFIFO_Trig, 0);
    applyStimulus(8'h15);
    checkOutput("trig4_at4", TxFIFO_Trig, 1);

    // Asynchronous reset mid-transfer.
    FIFOEn = 1'b0;
    applyStimulus(8'h77);
    checkOutput("pre_reset_ovf", Overflow, 1);
    RESETn = 1'b0;
    #2;
    checkOutput("areset_ready", TxDataReady, 0);
    checkOutput("areset_data", TxData, 8'h00);
    checkOutput("areset_level", TxFIFO_Level, 0);
    checkOutput("areset_ovf", Overflow, 0);
    checkOutput("areset_trig", TxFIFO_Trig, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
